// File: rtl/e603_sram_ctrl_pkg.sv
// e603_sram_pkg: power-state encodings and shared constants for the SRAM initiator
package e603_sram_pkg;
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;
    localparam int RSP_DEPTH = 3;

    function automatic int word_lsb(input int mw);
        return $clog2(mw);
    endfunction

    localparam int WORD_LSB = word_lsb(4);
endpackage

// File: rtl/e603_sram_ctrl_if.sv
// e603_sram_ctrl_if: command and response channels between a bus slave port and the SRAM initiator
interface e603_sram_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32
) ();
    localparam int MW = DW / 8;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/e603_sram_ctrl_rsp_fifo.sv
// e603_sram_rsp_fifo: small in-order response FIFO with occupancy count and same-cycle push/pop
module e603_sram_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wp_d  = push_i ? inc(wp_q) : wp_q;
        rp_d  = pop_i ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end

    // Head is forced to zero when empty so the response bus is quiet after reset.
    assign dout_o = (cnt_q != '0) ? mem_q[rp_q] : '0;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/e603_sram_ctrl.sv
// e603_sram_ctrl: valid/ready command channel to single-port SRAM strobes, in-order responses, idle light sleep
module e603_sram_ctrl
    import e603_sram_pkg::*;
#(
    parameter int DP          = 512,
    parameter int DW          = 32,
    parameter int MW          = DW / 8,
    parameter int AW          = 32,
    parameter int RAW         = $clog2(DP),
    parameter int IDLE_LS_CNT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    e603_sram_ctrl_if.slave bus,
    output logic            ram_cs_o,
    output logic            ram_we_o,
    output logic [MW-1:0]   ram_wem_o,
    output logic [RAW-1:0]  ram_addr_o,
    output logic [DW-1:0]   ram_din_o,
    input  logic [DW-1:0]   ram_dout_i,
    output logic            ram_ls_o,
    output logic            ram_ds_o,
    output logic            ram_sd_o
);
    localparam int LSB = word_lsb(MW);
    localparam int IW  = AW - LSB;
    localparam int CW  = $clog2(IDLE_LS_CNT + 2);
    localparam int FW  = $clog2(RSP_DEPTH + 1);

    logic [IW-1:0] idx;
    logic          in_range, acc, idle;
    logic          s1_vld_q, s1_rd_q, s1_err_q;
    logic [1:0]    st_q, st_d;
    logic          ls_q, ls_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [FW-1:0] fifo_cnt;
    logic [DW:0]   push_data, head;

    assign idx      = bus.cmd_addr[AW-1:LSB];
    assign in_range = idx < IW'(DP);
    // rst_n gates ready so the SRAM strobes drop the instant reset is applied.
    assign bus.cmd_ready = rst_n && (st_q == ST_ACTIVE) && (int'(fifo_cnt) + int'(s1_vld_q) < RSP_DEPTH);
    assign acc        = bus.cmd_valid && bus.cmd_ready;
    assign ram_cs_o   = acc && in_range;
    assign ram_we_o   = ram_cs_o && !bus.cmd_read;
    assign ram_wem_o  = ram_we_o ? bus.cmd_wmask : '0;
    assign ram_addr_o = ram_cs_o ? idx[RAW-1:0] : '0;
    assign ram_din_o  = ram_cs_o ? bus.cmd_wdata : '0;
    assign ram_ls_o   = ls_q;
    assign ram_ds_o   = 1'b0;
    assign ram_sd_o   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_rd_q  <= 1'b0;
            s1_err_q <= 1'b0;
        end else begin
            s1_vld_q <= acc;
            s1_rd_q  <= bus.cmd_read;
            s1_err_q <= !in_range;
        end
    end

    assign push_data = {(s1_rd_q && !s1_err_q) ? ram_dout_i : '0, s1_err_q};

    e603_sram_rsp_fifo #(.W(DW + 1), .DEPTH(RSP_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (s1_vld_q),
        .din_i  (push_data),
        .pop_i  (bus.rsp_valid && bus.rsp_ready),
        .dout_o (head),
        .cnt_o  (fifo_cnt)
    );

    assign bus.rsp_valid = fifo_cnt != '0;
    assign {bus.rsp_rdata, bus.rsp_err} = head;

    // Idle means nothing requested and nothing still in flight through S1.
    assign idle = !bus.cmd_valid && !s1_vld_q;

    always_comb begin
        st_d   = st_q;
        ls_d   = ls_q;
        idle_d = '0;
        if (st_q == ST_ACTIVE) begin
            idle_d = (idle && IDLE_LS_CNT != 0) ? idle_q + 1'b1 : '0;
            if (idle && IDLE_LS_CNT != 0 && idle_q == CW'(IDLE_LS_CNT - 1)) begin
                st_d   = ST_SLEEP;
                ls_d   = 1'b1;
                idle_d = '0;
            end
        end else if (st_q == ST_SLEEP) begin
            st_d = bus.cmd_valid ? ST_WAKE : ST_SLEEP;
            ls_d = !bus.cmd_valid;
        end else begin
            st_d = ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_ACTIVE;
            ls_q   <= 1'b0;
            idle_q <= '0;
        end else begin
            st_q   <= st_d;
            ls_q   <= ls_d;
            idle_q <= idle_d;
        end
    end
endmodule

// File: tb/tb_e603_sram_ctrl.sv
// tb_e603_sram_ctrl: randomized scoreboard bench for the SRAM initiator with a behavioural SRAM
module tb_e603_sram_ctrl;
    localparam int DP = 512, DW = 32, AW = 32, MW = 4, RAW = 9, IDLE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    e603_sram_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    logic           ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [MW-1:0]  ram_wem;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_din, ram_dout;

    e603_sram_ctrl #(.DP(DP), .DW(DW), .AW(AW), .IDLE_LS_CNT(IDLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_cs_o   (ram_cs),
        .ram_we_o   (ram_we),
        .ram_wem_o  (ram_wem),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout),
        .ram_ls_o   (ram_ls),
        .ram_ds_o   (ram_ds),
        .ram_sd_o   (ram_sd)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [DP];
    logic [31:0] sram [DP];
    int          n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0, last_lat = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;
    logic        rnd = 1'b0;
    logic        s_cs, s_we;
    logic [8:0]  s_addr;
    logic [3:0]  s_wem;
    logic [31:0] s_din;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a word-addressed memory with byte-mask writes; out-of-range gives err and zero data.
    task automatic model(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                         output logic [31:0] d, output logic e);
        int unsigned idx;
        idx = a >> 2;
        d = '0;
        e = 1'b0;
        if (idx >= DP) e = 1'b1;
        else if (rd) d = ref_mem[idx];
        else for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        logic        c, w;
        logic [3:0]  m;
        logic [8:0]  a;
        logic [31:0] d;
        for (int i = 0; i < DP; i++) sram[i] = init_word(i);
        ram_dout <= '0;
        forever begin
            @(negedge clk);
            c = ram_cs; w = ram_we; m = ram_wem; a = ram_addr; d = ram_din;
            @(posedge clk);
            if (c) begin
                ram_dout <= sram[a];
                if (w) for (int b = 0; b < 4; b++) if (m[b]) sram[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    end

    initial begin
        exp_t        x;
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < DP; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst_n) q.delete();
            else begin
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rdata %0h err %0b, expected no response", bus.rsp_rdata, bus.rsp_err);
                    end else begin
                        x = q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, x.d);
                        chk("rsp_err", bus.rsp_err, x.e);
                        last_lat = cyc - x.c;
                        chk("rsp_latency_ge2", last_lat >= 2, 1);
                        last_rd  = bus.rsp_rdata;
                        last_err = bus.rsp_err;
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    model(bus.cmd_read, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wmask, d, e);
                    q.push_back('{d, e, cyc});
                    n_acc++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) bus.rsp_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_wmask = m;
        while (1) begin
            @(negedge clk);
            if (bus.cmd_ready || n >= 300) break;
            n++;
            tick();
        end
        if (!bus.cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready 0 after %0d cycles, expected 1", n);
        end
        s_cs = ram_cs; s_we = ram_we; s_addr = ram_addr; s_wem = ram_wem; s_din = ram_din;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int          n;
        int          base;
        int unsigned idx;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wmask = '0;  bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_ls", ram_ls, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        bus.rsp_ready = 1'b1;
        send(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("t1_w_cs", s_cs, 1);
        chk("t1_w_we", s_we, 1);
        chk("t1_w_addr", s_addr, 4);
        chk("t1_w_wem", s_wem, 4'hF);
        chk("t1_w_din", s_din, 32'hDEADBEEF);
        send(1'b1, 32'h10, 32'h0, 4'h0);
        chk("t1_r_cs", s_cs, 1);
        chk("t1_r_we", s_we, 0);
        chk("t1_r_addr", s_addr, 4);
        drain();
        chk("t1_rdata", last_rd, 32'hDEADBEEF);
        chk("t1_latency", last_lat, 2);

        send(1'b0, 32'h20, 32'h11223344, 4'hF);
        send(1'b0, 32'h20, 32'h0000AB00, 4'b0010);
        send(1'b1, 32'h20, 32'h0, 4'h0);
        drain();
        chk("t2_rdata", last_rd, 32'h1122AB44);

        bus.rsp_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b1, 32'h40 + 32'(4 * i), 32'h0, 4'h0);
            end
            begin
                repeat (8) @(negedge clk);
                chk("t3_accepts", n_acc - base, 3);
                chk("t3_cmd_ready", bus.cmd_ready, 0);
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        drain();
        chk("t3_last_rdata", last_rd, init_word(20));

        send(1'b1, 32'h800, 32'h0, 4'h0);
        chk("t4_cs", s_cs, 0);
        drain();
        chk("t4_err", last_err, 1);
        chk("t4_rdata", last_rd, 0);

        // One busy cycle (S1) then IDLE idle cycles; sleep shows the cycle after.
        send(1'b1, 32'h10, 32'h0, 4'h0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ram_ls) break;
        end
        chk("t5_ls_cycle", n, 1 + IDLE + 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h14;
        @(negedge clk);
        chk("t5_sleep_ls", ram_ls, 1);
        chk("t5_sleep_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_wake_ls", ram_ls, 0);
        chk("t5_wake_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_active_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        drain();
        chk("t5_rdata", last_rd, init_word(5));

        bus.rsp_ready = 1'b0;
        send(1'b1, 32'h60, 32'h0, 4'h0);
        send(1'b1, 32'h64, 32'h0, 4'h0);
        tick(); tick(); tick();
        chk("t6_pre_rsp_valid", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1; bus.cmd_read = 1'b1; bus.cmd_addr = 32'h68;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_ram_cs", ram_cs, 0);
        chk("t6_ram_ls", ram_ls, 0);
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick(); tick();
        chk("t6_no_stale", bus.rsp_valid, 0);
        send(1'b1, 32'h68, 32'h0, 4'h0);
        drain();
        chk("t6_rdata", last_rd, init_word(26));

        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idx = ($urandom_range(9) == 0) ? DP + $urandom_range(1000) : $urandom_range(31);
            send($urandom_range(1) == 1, (idx << 2) | $urandom_range(3), $urandom, 4'($urandom));
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) tick();
        end
        rnd = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/e603_sram_ctrl.md
Name: e603_sram_ctrl

Overview:
- Initiator side of the single-port tech RAM interface. Converts a valid/ready command channel (read/write, byte address, data, byte mask) into SRAM cs/we/wem/addr/din strobes.
- Captures the 1-cycle-latency read data into an in-order response channel with backpressure.
- Manages SRAM light-sleep entry and exit on idle.
- Sits between a bus/ICB slave port and the tech RAM wrapper.

Parameters:
- DP, 512, RAM depth in words.
- DW, 32, data width; multiple of 8.
- MW, 4, mask width; always DW/8.
- AW, 32, command byte-address width.
- RAW, clog2(DP), RAM word-address width.
- IDLE_LS_CNT, 16, idle cycles before light sleep is asserted; 0 disables sleep.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_read  in  1  1=read, 0=write
- cmd_addr  in  AW  byte address
- cmd_wdata  in  DW  write data
- cmd_wmask  in  MW  byte write enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted when valid&ready
- rsp_rdata  out  DW  read data; 0 for writes and errors
- rsp_err  out  1  address out of range
- ram_cs  out  1  SRAM chip select
- ram_we  out  1  SRAM write enable
- ram_wem  out  MW  SRAM byte mask
- ram_addr  out  RAW  SRAM word address
- ram_din  out  DW  SRAM write data
- ram_dout  in  DW  SRAM read data, valid the cycle after a cs read
- ram_ls  out  1  light sleep (registered)
- ram_ds  out  1  deep sleep; constant 0
- ram_sd  out  1  shutdown; constant 0

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, including ram_ls; response FIFO empty; S1 empty; idle counter 0; state ACTIVE.
- Address decode:
  - word index = cmd_addr[AW-1:log2(MW)]; low bits are ignored (no misalignment error).
  - Index >= DP means out of range.
- SRAM drive: combinational from the accepted command. On valid&ready with an in-range address:
  - ram_cs=1, ram_we=!cmd_read, ram_wem=cmd_wmask (0 for reads), ram_addr=index[RAW-1:0], ram_din=cmd_wdata.
  - Out-of-range commands keep ram_cs=0.
- Pipeline stage S1 (registered):
  - Holds vld, rd, err for the command accepted last cycle.
  - At the next cycle it pushes {rdata, err} into the response FIFO.
  - rdata = ram_dout for an in-range read, otherwise 0.
- Response FIFO:
  - 3 entries, in order; rsp_* driven from the head entry; pop on rsp_valid&rsp_ready.
  - Simultaneous push and pop is allowed at any occupancy.
- Flow control:
  - cmd_ready = (state==ACTIVE) && (fifo_cnt + s1_vld < 3).
  - No combinational path from rsp_ready or cmd_valid to cmd_ready.
  - This gives 1 command/cycle sustained while rsp_ready=1. Overflow is impossible by construction.
- Latency: accept at cycle t -> rsp_valid at t+2 at the earliest.
- Writes always produce a response (rdata=0, err=0 if in range).
- Power FSM:
  - ACTIVE: idle_cnt increments each cycle with !cmd_valid && !s1_vld, and clears otherwise. When idle_cnt==IDLE_LS_CNT-1 and the cycle is still idle -> SLEEP, ram_ls<=1.
  - SLEEP: ram_ls=1, cmd_ready=0. cmd_valid -> WAKE, ram_ls<=0.
  - WAKE: cmd_ready=0 for exactly one cycle -> ACTIVE, idle_cnt=0.
  - Pending FIFO responses continue to drain in SLEEP and WAKE.
  - IDLE_LS_CNT=0: the FSM stays ACTIVE forever.
- Reset mid-operation: S1 and the FIFO are flushed, in-flight responses are dropped, and ram_cs deasserts immediately.
- cmd_* are ignored when not accepted; the master must hold them stable while valid and not ready.

Decomposition:
- Package e603_sram_pkg holds:
  - the power-state encodings (ACTIVE, SLEEP, WAKE);
  - the response FIFO depth constant (3);
  - the word-index helper constant log2(MW).
- One sub-module, e603_sram_rsp_fifo: a 3-entry synchronous FIFO with count output and simultaneous push/pop.

Test Plan:
1. Write 0xDEADBEEF, mask 4'b1111 to addr 0x10, then read 0x10 with rsp_ready=1. Required: ram_cs/ram_we pulse with ram_addr=4; read response rdata=0xDEADBEEF, err=0, 2 cycles after accept.
2. Write mask 4'b0010, data 0x0000AB00, to a word holding 0x11223344, then read it. Required: rdata=0x1122AB44.
3. Hold rsp_ready=0 and issue 5 back-to-back reads. Required: cmd_ready drops after 3 accepts; responses are neither lost nor reordered after rsp_ready=1.
4. Read byte addr 4*DP (DP=512 -> 0x800). Required: ram_cs stays 0; response err=1, rdata=0.
5. Idle for 16 cycles. Required: ram_ls=1 at cycle 16; cmd_valid then gives ram_ls=0 next cycle, cmd_ready=1 one cycle later, and the read completes correctly.
6. Assert rst_n=0 with 2 responses queued. Required: rsp_valid, ram_cs and ram_ls are 0 immediately; after release the first new read gets the correct data.
